nibble_serial_addsub: RTL and testbench
=======================================

Name: nibble_serial_addsub

Overview:
Multi-cycle controller that performs N-nibble add/subtract by time-sharing one adder_4bit instance, one nibble per cycle, LSB first. It latches the operands, sequences the nibble index and the inter-nibble carry, and assembles the result. It is the wide add/sub unit for paths where area matters more than latency.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_start  input  1  operation request; sampled only in IDLE.
i_sub  input  1  0 = A+B, 1 = A-B; sampled with i_start.
i_a  input  W  operand A; sampled with i_start.
i_b  input  W  operand B; sampled with i_start.
o_busy  output  1  high while in RUN.
o_done  output  1  one-cycle pulse when the result is valid.
o_result  output  W  sum or difference; held until the next accepted start.
o_cout  output  1  carry out of the MSB nibble; for subtract, 1 = no borrow.
o_ovf  output  1  signed two's-complement overflow; held like o_result.

Behaviour:
- Clocking: one clock (i_clk). Reset is synchronous and active-high (i_rst).
- Reset state: IDLE. o_busy=0, o_done=0, o_result=0, o_cout=0, o_ovf=0, carry register=0, index=0.
- States: IDLE, RUN, DONE.
- IDLE, i_start=1: capture operand register A := i_a.
- IDLE, i_start=1: capture B := i_sub ? ~i_b : i_b.
- IDLE, i_start=1: carry := i_sub; index := 0; clear o_result, o_cout, o_ovf; next state RUN.
- IDLE, i_start=0: stay in IDLE, outputs hold.
- RUN, every cycle: adder inputs are A[4*idx+:4], B[4*idx+:4] and the carry register.
- RUN, every cycle: write the adder sum to o_result[4*idx+:4]; carry := adder cout; idx := idx+1.
- RUN, when idx == NIBBLES-1: o_cout := adder cout.
- RUN, when idx == NIBBLES-1: o_ovf := (A[W-1] == B[W-1]) && (sum[3] != A[W-1]), where B is the post-inversion value.
- RUN, when idx == NIBBLES-1: next state DONE.
- DONE: o_done=1 for exactly one cycle, then unconditionally to IDLE.
- Latency: start sampled at edge k; RUN occupies cycles k+1 .. k+NIBBLES; o_done is high in cycle k+NIBBLES+1. Throughput is one operation per NIBBLES+2 cycles.
- o_busy=1 only in RUN.
- i_start in RUN or DONE: ignored, not queued. This includes a start asserted in the same cycle as o_done.
- Operand changes on i_a, i_b or i_sub after acceptance have no effect.
- Reset in any state, including mid-RUN: returns to the reset state on that edge. The partial result is discarded. No o_done is produced for the aborted operation.
- Wrap-around: results are modulo 2^W; the carry out of the MSB nibble is reported only on o_cout.
- o_result is undefined-for-use during RUN, because it fills incrementally. It is defined when o_done=1 and afterwards until the next start.

Decomposition:
- Shared package: NIBBLE_W=4; state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; index width derived as clog2(NIBBLES).
- Sub-module: exactly one adder_4bit instance, the shared datapath. No other sub-modules.
- The FSM, operand registers, carry register and result assembly live in this module.

Test Plan:
1. NIBBLES=4, add 0x1234 + 0x0FFF → o_done in cycle k+5, o_result=0x2233, o_cout=0, o_ovf=0; o_busy high for exactly 4 cycles.
2. Add 0xFFFF + 0x0001 → o_result=0x0000, o_cout=1, o_ovf=0; full carry ripples across all 4 nibble cycles.
3. Subtract 0x0005 - 0x0007 → o_result=0xFFFE, o_cout=0 (borrow); subtract 0x0007 - 0x0005 → o_result=0x0002, o_cout=1.
4. Add 0x7FFF + 0x0001 → o_result=0x8000, o_ovf=1; subtract 0x8000 - 0x0001 → o_result=0x7FFF, o_ovf=1.
5. Accept 0x1111 + 0x2222, then pulse i_start with other operands in RUN cycle 2 and again in the DONE cycle → both ignored; single o_done, o_result=0x3333.
6. Assert i_rst in RUN cycle 2 → next cycle all outputs 0, state IDLE, no o_done. A start issued right after reset completes normally with the correct result.

Source files
------------

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared constants and types for the nibble-serial add/subtract unit.
// The controller sequences one 4-bit adder across all nibbles of the operands.
package nibble_serial_addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for a given nibble count; at least one bit even for tiny counts.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_adder_4bit.sv
// Plain 4-bit ripple adder with carry in/out; the single shared datapath
// element that the serial controller reuses on every nibble cycle.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign sum   = total[3:0];
  assign cout  = total[4];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle wide add/subtract: latches operands, then feeds one nibble per
// cycle (LSB first) through a shared 4-bit adder, threading the carry between nibbles.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_sub,
  input  logic [4*NIBBLES-1:0]    i_a,
  input  logic [4*NIBBLES-1:0]    i_b,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*NIBBLES-1:0]    o_result,
  output logic                    o_cout,
  output logic                    o_ovf
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  assign nib_a = a_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];
  assign nib_b = b_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];

  adder_4bit u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Subtraction is A + ~B + 1: B is inverted at capture and the +1 enters as the initial carry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_cout   <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            a_reg    <= i_a;
            b_reg    <= i_sub ? ~i_b : i_b;
            carry    <= i_sub;
            idx      <= '0;
            o_result <= '0;
            o_cout   <= 1'b0;
            o_ovf    <= 1'b0;
            o_busy   <= 1'b1;
            state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          o_result[NIBBLE_W*int'(idx) +: NIBBLE_W] <= nib_sum;
          carry <= nib_cout;
          if (idx == LAST_IDX) begin
            // Overflow compares against the inverted B so one rule covers add and subtract.
            o_cout <= nib_cout;
            o_ovf  <= (a_reg[W-1] == b_reg[W-1]) && (nib_sum[NIBBLE_W-1] != a_reg[W-1]);
            idx    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ST_DONE: begin
          o_done <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          o_busy <= 1'b0;
          o_done <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed and randomized checks of nibble_serial_addsub (NIBBLES=4) against
// an arithmetic reference model of wide add/subtract with carry and overflow.
module tb_nibble_serial_addsub;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_sub;
  logic [W-1:0]  i_a;
  logic [W-1:0]  i_b;
  logic          o_busy;
  logic          o_done;
  logic [W-1:0]  o_result;
  logic          o_cout;
  logic          o_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_addsub #(.NIBBLES(N)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_sub    (i_sub),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_cout   (o_cout),
    .o_ovf    (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic modulo 2^W; returns {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int unsigned ai, bi, s;
    logic [W-1:0] r;
    logic c, v;
    ai = a;
    bi = b;
    if (sub) begin
      s = ai - bi;
      r = s[W-1:0];
      c = (ai >= bi);
      v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      s = ai + bi;
      r = s[W-1:0];
      c = (s >= (1 << W));
      v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {v, c, r};
  endfunction

  // Issues one operation and watches a fixed window of cycles after acceptance.
  // With inject set, extra starts are pulsed in RUN cycle 2 and in the DONE cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] exp_r, input logic exp_c,
                        input logic exp_v, input bit inject);
    int busy_cnt, done_cnt, done_cyc;
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    @(negedge clk);
    i_a = a; i_b = b; i_sub = sub; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_a = W'($urandom); i_b = W'($urandom); i_sub = 1'($urandom);
    for (int m = 1; m <= N + 4; m++) begin
      @(negedge clk);
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = m;
      end
      i_start = inject && (m == 2 || m == N + 1);
      if (i_start) begin
        i_a = W'($urandom); i_b = W'($urandom); i_sub = 1'($urandom);
      end
    end
    i_start = 1'b0;
    check({tag, ".done_cycle"}, done_cyc, N + 1);
    check({tag, ".done_count"}, done_cnt, 1);
    check({tag, ".busy_cycles"}, busy_cnt, N);
    check({tag, ".result"}, o_result, exp_r);
    check({tag, ".cout"}, o_cout, exp_c);
    check({tag, ".ovf"}, o_ovf, exp_v);
  endtask

  task automatic run_model(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W+1:0] e;
    e = model(a, b, sub);
    run_op(tag, a, b, sub, e[W-1:0], e[W], e[W+1], 1'b0);
  endtask

  initial begin
    int busy_seen, done_seen;
    i_rst = 1'b1; i_start = 1'b0; i_sub = 1'b0; i_a = '0; i_b = '0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    check("reset.busy", o_busy, 0);
    check("reset.done", o_done, 0);
    check("reset.result", o_result, 0);
    check("reset.cout", o_cout, 0);
    check("reset.ovf", o_ovf, 0);

    run_op("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    run_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("ignore_starts", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
    check("ignore_starts.idle_busy", o_busy, 0);

    // Abort mid-RUN with reset; the aborted operation must never report done.
    @(negedge clk);
    i_a = 16'hABCD; i_b = 16'h1357; i_sub = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("abort.busy", o_busy, 0);
    check("abort.done", o_done, 0);
    check("abort.result", o_result, 0);
    check("abort.cout", o_cout, 0);
    check("abort.ovf", o_ovf, 0);
    busy_seen = 0;
    done_seen = 0;
    repeat (N + 3) begin
      @(negedge clk);
      if (o_busy) busy_seen++;
      if (o_done) done_seen++;
    end
    check("abort.no_done", done_seen, 0);
    check("abort.stays_idle", busy_seen, 0);
    run_op("after_abort", 16'h4321, 16'h1111, 1'b1, 16'h3210, 1'b1, 1'b0, 1'b0);

    run_model("sub_b_zero", 16'h8001, 16'h0000, 1'b1);
    run_model("sub_b_8000", 16'h0001, 16'h8000, 1'b1);
    for (int t = 0; t < 16; t++) begin
      run_model($sformatf("rand%0d", t), W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
